serial_subtractor_ctrl: RTL and testbench

SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

---
 rtl/serial_subtractor_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
//   Bit-serial subtractor. It computes (a - b - bin) mod 2^WIDTH one bit per
//   clock, starting at the LSB, and produces the final borrow.
//   A start seen in IDLE captures the operands. WIDTH RUN cycles follow.
//   A single DONE cycle then presents the registered result.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request a subtraction (sampled in IDLE only)
//   a      in   WIDTH  minuend, captured on the accepting edge
//   b      in   WIDTH  subtrahend, captured on the accepting edge
//   bin    in   1      borrow-in, captured on the accepting edge
//   diff   out  WIDTH  registered difference, held between operations
//   bout   out  1      registered final borrow-out
//   busy   out  1      high during the WIDTH serial steps
//   done   out  1      one-cycle pulse when diff/bout are updated
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    // Sized to hold WIDTH, so the counter cannot wrap on the final step.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_bout;
    logic [CW-1:0]    r_cnt;

    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    // One full-subtractor step on the current LSBs
    always_comb begin
        w_d        = r_a[0] ^ r_b[0] ^ r_br;
        w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
        // Result bits enter at the MSB, so after WIDTH steps bit 0 is at the LSB.
        w_res_next = {w_d, r_res[WIDTH-1:1]};
        w_last     = (r_cnt == CW'(WIDTH - 1));
    end

    // Next-state logic and status outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_diff <= '0;
            r_br   <= 1'b0;
            r_bout <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_br  <= bin;
                        r_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff <= w_res_next;
                        r_bout <= w_br_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl
//   Self-checking bench for serial_subtractor_ctrl with WIDTH=8.
//   Each operation is checked cycle by cycle against a plain integer
//   (a - b - bin) model. The bench also checks the busy/done sequencing and
//   that the output result is held.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;

    int n_cmp;
    int n_err;

    serial_subtractor_ctrl #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // mode 0: start dropped after acceptance, inputs kept quiet
    // mode 1: random start pulses and operand changes while the operation runs
    // mode 2: start held high throughout, operands scrambled during RUN
    // The task is called at a falling edge with the DUT in IDLE.
    // It returns at a falling edge with the DUT in IDLE again.
    task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input logic op_bin, input int mode);
        int           d;
        logic [W-1:0] exp_diff;
        logic         exp_bout;
        logic [W:0]   prev;

        d        = int'(op_a) - int'(op_b) - int'(op_bin);
        exp_bout = (d < 0);
        exp_diff = W'((d + (1 << W)) % (1 << W));
        prev     = {bout, diff};

        a     = op_a;
        b     = op_b;
        bin   = op_bin;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (mode == 0) start = 1'b0;
        if (mode != 0) begin
            a   = W'($urandom);
            b   = W'($urandom);
            bin = 1'($urandom);
        end
        if (mode == 1) start = 1'($urandom);

        for (int c = 0; c < W; c++) begin
            @(negedge clk);
            check("busy_done_run", {30'd0, busy, done}, 32'h2);
            check("hold_run", {23'd0, bout, diff}, {23'd0, prev});
            if (mode != 0) begin
                a   = W'($urandom);
                b   = W'($urandom);
                bin = 1'($urandom);
            end
            if (mode == 1) start = 1'($urandom);
        end

        @(negedge clk);
        check("busy_done_done", {30'd0, busy, done}, 32'h1);
        check("diff", {24'd0, diff}, {24'd0, exp_diff});
        check("bout", {31'd0, bout}, {31'd0, exp_bout});
        if (mode == 1) start = 1'($urandom);

        @(negedge clk);
        check("busy_done_idle", {30'd0, busy, done}, 32'h0);
        check("hold_idle", {23'd0, bout, diff}, {22'd0, exp_bout, exp_diff});
        if (mode != 2) start = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        rst_n = 1'b1;

        // Reset must act without a clock edge
        #1 rst_n = 1'b0;
        #1;
        check("reset_out", {21'd0, busy, done, bout, diff}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {21'd0, busy, done, bout, diff}, 32'h0);

        // Directed vectors
        do_op(8'h05, 8'h03, 1'b0, 0);
        do_op(8'h00, 8'h01, 1'b0, 0);
        do_op(8'h80, 8'h80, 1'b1, 0);
        do_op(8'hFF, 8'h00, 1'b0, 0);
        do_op(8'h00, 8'h00, 1'b0, 0);
        do_op(8'h00, 8'hFF, 1'b1, 1);

        // start held continuously: the same result every W+2 cycles
        for (int i = 0; i < 3; i++) do_op(8'h10, 8'h01, 1'b0, 2);
        start = 1'b0;
        @(negedge clk);

        // Reset in the fourth RUN cycle aborts the operation
        a     = 8'h55;
        b     = 8'h22;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 4; c++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out", {21'd0, busy, done, bout, diff}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < W + 4; c++) begin
            @(negedge clk);
            check("no_done_after_abort", {30'd0, busy, done}, 32'h0);
        end
        do_op(8'h09, 8'h04, 1'b0, 0);

        // Randomized operations in all three stimulus modes
        for (int n = 0; n < 1000; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
        start = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
